// File: rtl/block_lock_fsm_pkg.sv
// Shared 10GBASE-R PCS definitions: sync-header codes and block-lock state encoding.
package block_lock_fsm_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic {
        ST_TEST_SH   = 1'b0,
        ST_SLIP_WAIT = 1'b1
    } lock_state_e;

    function automatic logic sh_is_ok(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// 66b block-lock FSM: judges sync headers per window and asks the gearbox to slip.
// Outputs registered, one cycle after the header; cycles without a valid header only drop o_slip.
module block_lock_fsm
    import block_lock_fsm_pkg::*;
#(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32
) (
    input  logic       i_rxc,
    input  logic       i_reset,
    input  logic       i_header_valid,
    input  logic [1:0] i_header,
    output logic       o_slip,
    output logic       o_block_lock
);

    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVLD_MAX + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(SH_CNT_MAX);
    localparam logic [IW-1:0] INVLD_LAST = IW'(SH_INVLD_MAX);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT);

    lock_state_e   state_q, state_d;
    logic [CW-1:0] sh_cnt_q, sh_cnt_d;
    logic [IW-1:0] sh_invld_cnt_q, sh_invld_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          slip_q, slip_d;
    logic          lock_q, lock_d;

    logic          sh_ok;
    logic [CW-1:0] cnt_n;
    logic [IW-1:0] invld_n;
    logic [WW-1:0] wait_n;

    always_ff @(posedge i_rxc) begin
        if (i_reset) begin
            state_q        <= ST_TEST_SH;
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
            wait_cnt_q     <= '0;
            slip_q         <= 1'b0;
            lock_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_cnt_q       <= sh_cnt_d;
            sh_invld_cnt_q <= sh_invld_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            slip_q         <= slip_d;
            lock_q         <= lock_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sh_cnt_d       = sh_cnt_q;
        sh_invld_cnt_d = sh_invld_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        slip_d         = 1'b0;
        lock_d         = lock_q;
        sh_ok          = sh_is_ok(i_header);
        cnt_n          = sh_cnt_q + CW'(1);
        invld_n        = sh_invld_cnt_q + IW'(!sh_ok);
        wait_n         = wait_cnt_q + WW'(1);

        if (i_header_valid) begin
            unique case (state_q)
                ST_TEST_SH: begin
                    // Slip wins over window completion when both land on the same header.
                    if (!sh_ok && (!lock_q || invld_n == INVLD_LAST)) begin
                        lock_d         = 1'b0;
                        slip_d         = 1'b1;
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                        wait_cnt_d     = '0;
                        state_d        = ST_SLIP_WAIT;
                    end else if (cnt_n == CNT_LAST) begin
                        if (invld_n == '0) begin
                            lock_d = 1'b1;
                        end
                        sh_cnt_d       = '0;
                        sh_invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d       = cnt_n;
                        sh_invld_cnt_d = invld_n;
                    end
                end
                ST_SLIP_WAIT: begin
                    // Header contents are meaningless until the gearbox has settled.
                    if (wait_n == WAIT_LAST) begin
                        wait_cnt_d = '0;
                        state_d    = ST_TEST_SH;
                    end else begin
                        wait_cnt_d = wait_n;
                    end
                end
                default: state_d = ST_TEST_SH;
            endcase
        end
    end

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;

endmodule

// File: tb/tb_block_lock_fsm.sv
// Self-checking bench for block_lock_fsm with default parameters (64/16/32).
module tb_block_lock_fsm;

    logic       i_rxc = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_header_valid = 1'b0;
    logic [1:0] i_header = 2'b00;
    logic       o_slip;
    logic       o_block_lock;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] hdr;
        logic       exp_slip;
        logic       exp_lock;
    } vec_t;

    typedef struct {
        logic slip;
        logic lock;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    vec_t  tbl[8];

    block_lock_fsm #(
        .SH_CNT_MAX  (64),
        .SH_INVLD_MAX(16),
        .SLIP_WAIT   (32)
    ) dut (
        .i_rxc         (i_rxc),
        .i_reset       (i_reset),
        .i_header_valid(i_header_valid),
        .i_header      (i_header),
        .o_slip        (o_slip),
        .o_block_lock  (o_block_lock)
    );

    always #5 i_rxc = ~i_rxc;

    function automatic logic [1:0] clean_hdr(input int i);
        return (i % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    // Drive one cycle, queue its expectation, then compare just after the edge.
    task automatic step(input logic rst, input logic vld, input logic [1:0] hdr,
                        input logic es, input logic el, input string tag);
        exp_t e;
        string t;
        i_reset        = rst;
        i_header_valid = vld;
        i_header       = hdr;
        e.slip = es;
        e.lock = el;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge i_rxc);
        #1;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            if (o_slip !== e.slip || o_block_lock !== e.lock) begin
                miscompares++;
                $display("FAIL %s @%0t: slip=%b lock=%b, expected slip=%b lock=%b",
                         t, $time, o_slip, o_block_lock, e.slip, e.lock);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, tag);
    endtask

    // From a fresh window while unlocked: 64 clean headers, lock on the last.
    task automatic lock_up(input string tag);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, clean_hdr(i), 1'b0, (i == 63), tag);
        end
    endtask

    initial begin
        int hdrs;

        tbl[0] = '{rst: 1'b1, vld: 1'b0, hdr: 2'b00, exp_slip: 1'b0, exp_lock: 1'b0};
        tbl[1] = '{rst: 1'b0, vld: 1'b0, hdr: 2'b00, exp_slip: 1'b0, exp_lock: 1'b0};
        tbl[2] = '{rst: 1'b0, vld: 1'b1, hdr: 2'b01, exp_slip: 1'b0, exp_lock: 1'b0};
        tbl[3] = '{rst: 1'b0, vld: 1'b1, hdr: 2'b00, exp_slip: 1'b1, exp_lock: 1'b0};
        tbl[4] = '{rst: 1'b0, vld: 1'b0, hdr: 2'b00, exp_slip: 1'b0, exp_lock: 1'b0};
        tbl[5] = '{rst: 1'b0, vld: 1'b1, hdr: 2'b11, exp_slip: 1'b0, exp_lock: 1'b0};
        tbl[6] = '{rst: 1'b1, vld: 1'b1, hdr: 2'b00, exp_slip: 1'b0, exp_lock: 1'b0};
        tbl[7] = '{rst: 1'b0, vld: 1'b1, hdr: 2'b10, exp_slip: 1'b0, exp_lock: 1'b0};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].hdr, tbl[i].exp_slip, tbl[i].exp_lock,
                 $sformatf("table[%0d]", i));
        end

        // Clean window after reset: lock after 64th header, never a slip.
        do_reset("clean_reset");
        lock_up("clean_lock");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, clean_hdr(i), 1'b0, 1'b1, "clean_hold");

        // Same window with random valid gaps: lock point counted in headers.
        do_reset("gap_reset");
        hdrs = 0;
        while (hdrs < 64) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, "gap_idle");
            end else begin
                step(1'b0, 1'b1, clean_hdr(hdrs), 1'b0, (hdrs == 63), "gap_hdr");
                hdrs++;
            end
        end
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, "gap_after");

        // Unlocked bad header at index 5, then 32 ignored headers, then counting resumes.
        do_reset("slip_reset");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, clean_hdr(i), 1'b0, 1'b0, "slip_pre");
        step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, "slip_pulse");
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "slip_wait");
        lock_up("slip_relock");

        // Locked: 15 invalid in a window tolerated, 16 forces a slip.
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, (i < 15) ? 2'b11 : clean_hdr(i), 1'b0, 1'b1, "tol15");
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 2'b11, (i == 15), (i != 15), "bad16");
        end
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, "bad16_after");

        // Locked: 16th invalid lands on header 64 -> slip beats window completion.
        do_reset("edge_reset");
        lock_up("edge_lock");
        for (int i = 0; i < 48; i++) step(1'b0, 1'b1, clean_hdr(i), 1'b0, 1'b1, "edge_clean");
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 2'b11, (i == 15), (i != 15), "edge_bad");
        end
        step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, "edge_after");

        // Reset during SLIP_WAIT, then reset at header 40 of a locked window.
        do_reset("rst_reset");
        step(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, "rst_slip");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, "rst_wait");
        do_reset("rst_in_wait");
        lock_up("rst_relock1");
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, clean_hdr(i), 1'b0, 1'b1, "rst_win40");
        step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, "rst_override");
        lock_up("rst_relock2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
